// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module : mem_arbiter_if
// Requester, RAM-macro and framebuffer-status bundle for mem_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) ();
   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_gnt;

   logic              dp_req;
   logic [ADDR_W-1:0] dp_addr;
   logic              dp_gnt;
   logic              dp_rvalid;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;

   logic [DATA_W-1:0] rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              fb_dirty;
   logic              fb_clr;

   modport slave (
      input  ld_req, ld_addr, ld_wdata,
      output ld_gnt,
      input  dp_req, dp_addr,
      output dp_gnt, dp_rvalid,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid,
      output rdata,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata,
      output fb_dirty,
      input  fb_clr
   );

   modport master (
      output ld_req, ld_addr, ld_wdata,
      input  ld_gnt,
      output dp_req, dp_addr,
      input  dp_gnt, dp_rvalid,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid,
      input  rdata,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata,
      input  fb_dirty,
      output fb_clr
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Single-port CHIP-8 RAM arbiter: loader > round-robin(display, CPU).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int              ADDR_W  = 12,
   parameter int              DATA_W  = 8,
   parameter logic [ADDR_W-1:0] FB_BASE = 12'h100
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   mem_arbiter_if.slave  arb_if
);

   localparam logic [ADDR_W:0] FB_SPAN = (ADDR_W+1)'(256);

   typedef enum logic {
      RR_DP  = 1'b0,
      RR_CPU = 1'b1
   } rr_t;

   rr_t               rr_q;
   logic              ld_gnt_q;
   logic              dp_gnt_q;
   logic              cpu_gnt_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_we_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              dp_pend_q;
   logic              cpu_pend_q;
   logic              dp_rvalid_q;
   logic              cpu_rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic              fb_dirty_q;

   logic              ld_elig;
   logic              dp_elig;
   logic              cpu_elig;
   logic              ld_gnt_d;
   logic              dp_gnt_d;
   logic              cpu_gnt_d;
   logic [ADDR_W-1:0] fb_off;
   logic              fb_set_d;

   always_comb begin
      ld_elig  = arb_if.ld_req & ~ld_gnt_q;
      // A held loader request also blocks its masked cycle so a load runs uninterrupted.
      dp_elig  = arb_if.dp_req  & ~dp_gnt_q  & ~arb_if.ld_req;
      cpu_elig = arb_if.cpu_req & ~cpu_gnt_q & ~arb_if.ld_req;

      ld_gnt_d  = ld_elig;
      dp_gnt_d  = dp_elig  & (~cpu_elig | (rr_q == RR_CPU));
      cpu_gnt_d = cpu_elig & (~dp_elig  | (rr_q == RR_DP));

      fb_off   = arb_if.cpu_addr - FB_BASE;
      fb_set_d = cpu_gnt_d & arb_if.cpu_we & ({1'b0, fb_off} < FB_SPAN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q         <= RR_CPU;
         ld_gnt_q     <= 1'b0;
         dp_gnt_q     <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         dp_pend_q    <= 1'b0;
         cpu_pend_q   <= 1'b0;
         dp_rvalid_q  <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         rdata_q      <= '0;
         fb_dirty_q   <= 1'b0;
      end else begin
         ld_gnt_q  <= ld_gnt_d;
         dp_gnt_q  <= dp_gnt_d;
         cpu_gnt_q <= cpu_gnt_d;

         mem_we_q <= 1'b0;
         if (ld_gnt_d) begin
            mem_addr_q  <= arb_if.ld_addr;
            mem_wdata_q <= arb_if.ld_wdata;
            mem_we_q    <= 1'b1;
         end else if (dp_gnt_d) begin
            mem_addr_q  <= arb_if.dp_addr;
         end else if (cpu_gnt_d) begin
            mem_addr_q  <= arb_if.cpu_addr;
            mem_wdata_q <= arb_if.cpu_wdata;
            mem_we_q    <= arb_if.cpu_we;
         end

         if (dp_gnt_d || cpu_gnt_d) begin
            rr_q <= dp_gnt_d ? RR_DP : RR_CPU;
         end

         // Stage 1: RAM samples the address; stage 2: its output is captured.
         dp_pend_q    <= dp_gnt_q;
         cpu_pend_q   <= cpu_gnt_q & ~mem_we_q;
         dp_rvalid_q  <= dp_pend_q;
         cpu_rvalid_q <= cpu_pend_q;
         if (dp_pend_q || cpu_pend_q) begin
            rdata_q <= arb_if.mem_rdata;
         end

         if (fb_set_d) begin
            fb_dirty_q <= 1'b1;
         end else if (arb_if.fb_clr) begin
            fb_dirty_q <= 1'b0;
         end
      end
   end

   assign arb_if.ld_gnt     = ld_gnt_q;
   assign arb_if.dp_gnt     = dp_gnt_q;
   assign arb_if.cpu_gnt    = cpu_gnt_q;
   assign arb_if.dp_rvalid  = dp_rvalid_q;
   assign arb_if.cpu_rvalid = cpu_rvalid_q;
   assign arb_if.rdata      = rdata_q;
   assign arb_if.mem_addr   = mem_addr_q;
   assign arb_if.mem_we     = mem_we_q;
   assign arb_if.mem_wdata  = mem_wdata_q;
   assign arb_if.fb_dirty   = fb_dirty_q;

endmodule

`default_nettype wire
